// File: rtl/vga_text_if.sv
// Byte-stream input and character-buffer write port of the VGA text controller.
// The slave view belongs to the controller; the master view to whoever drives bytes in.
interface vga_text_if #(
  parameter int unsigned BUF_ADDR_WIDTH   = 10,
  parameter int unsigned C_AXI_DATA_WIDTH = 32
);
  logic                            char_valid_i;
  logic [7:0]                      char_data_i;
  logic                            char_ready_o;
  logic                            buf_wr_en_o;
  logic [BUF_ADDR_WIDTH-1:0]       buf_waddr_o;
  logic [C_AXI_DATA_WIDTH-1:0]     buf_wdata_o;
  logic [C_AXI_DATA_WIDTH/8-1:0]   buf_wstrb_o;
  logic [6:0]                      cursor_col_o;
  logic [4:0]                      cursor_row_o;
  logic                            busy_o;

  modport slave (
    input  char_valid_i,
    input  char_data_i,
    output char_ready_o,
    output buf_wr_en_o,
    output buf_waddr_o,
    output buf_wdata_o,
    output buf_wstrb_o,
    output cursor_col_o,
    output cursor_row_o,
    output busy_o
  );

  modport master (
    output char_valid_i,
    output char_data_i,
    input  char_ready_o,
    input  buf_wr_en_o,
    input  buf_waddr_o,
    input  buf_wdata_o,
    input  buf_wstrb_o,
    input  cursor_col_o,
    input  cursor_row_o,
    input  busy_o
  );
endinterface

// File: rtl/vga_text_ctrl.sv
// Turns a byte stream into character-buffer writes, tracking a cursor and handling
// CR/LF/BS/FF; rows are cleared on advance instead of scrolling.
module vga_text_ctrl #(
  parameter int unsigned N_COL            = 80,
  parameter int unsigned N_ROW            = 30,
  parameter int unsigned BUF_ADDR_WIDTH   = 10,
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter bit          CLEAR_ON_RESET   = 1'b1
) (
  input logic       clk_i,
  input logic       rst_i,
  vga_text_if.slave bus_io
);

  localparam int unsigned Lanes = C_AXI_DATA_WIDTH / 8;
  localparam int unsigned LaneW = $clog2(Lanes);

  localparam logic [9:0] RowWords = 10'(N_COL / Lanes);
  localparam logic [9:0] AllWords = 10'(N_COL * N_ROW / Lanes);
  localparam logic [6:0] LastCol  = 7'(N_COL - 1);
  localparam logic [4:0] LastRow  = 5'(N_ROW - 1);

  localparam logic [7:0] ChBs = 8'h08;
  localparam logic [7:0] ChLf = 8'h0A;
  localparam logic [7:0] ChFf = 8'h0C;
  localparam logic [7:0] ChCr = 8'h0D;

  localparam logic [C_AXI_DATA_WIDTH-1:0] Blank   = {Lanes{8'h20}};
  localparam logic [Lanes-1:0]            LaneOne = {{(Lanes-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StWrite, StClearRow, StClearAll} state_e;

  state_e                      state_q;
  logic [6:0]                  col_q;
  logic [4:0]                  row_q;
  logic [9:0]                  cnt_q;
  logic                        wrap_q;
  logic                        wr_en_q;
  logic [BUF_ADDR_WIDTH-1:0]   waddr_q;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [Lanes-1:0]            wstrb_q;

  logic [7:0]                  ch;
  logic                        is_print;
  logic [6:0]                  tgt_col;
  logic [6:0]                  ch7;
  logic [11:0]                 tile;
  logic [4:0]                  row_adv;
  logic [BUF_ADDR_WIDTH-1:0]   char_addr;
  logic [Lanes-1:0]            char_strb;
  logic [C_AXI_DATA_WIDTH-1:0] char_data;

  // First word of a row in the clear sequence, offset by idx.
  function automatic logic [BUF_ADDR_WIDTH-1:0] row_word(input logic [4:0] row,
                                                          input logic [9:0] idx);
    logic [9:0] w;
    w = 10'(row) * RowWords + idx;
    return BUF_ADDR_WIDTH'(w);
  endfunction

  assign ch = bus_io.char_data_i;

  // Printable writes land at the current column; BS writes a space one column back.
  always_comb begin
    is_print  = (ch >= 8'h20) && (ch <= 8'h7E);
    tgt_col   = is_print ? col_q : col_q - 7'd1;
    ch7       = is_print ? ch[6:0] : 7'h20;
    tile      = 12'(row_q) * 12'(N_COL) + 12'(tgt_col);
    char_addr = BUF_ADDR_WIDTH'(tile >> LaneW);
    char_strb = LaneOne << tile[LaneW-1:0];
    char_data = {Lanes{1'b0, ch7}};
    row_adv   = (row_q == LastRow) ? 5'd0 : row_q + 5'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CLEAR_ON_RESET ? StClearAll : StIdle;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      wr_en_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus_io.char_valid_i) begin
            if (is_print) begin
              wr_en_q <= 1'b1;
              waddr_q <= char_addr;
              wdata_q <= char_data;
              wstrb_q <= char_strb;
              state_q <= StWrite;
              if (col_q == LastCol) begin
                col_q  <= '0;
                row_q  <= row_adv;
                wrap_q <= 1'b1;
              end else begin
                col_q  <= col_q + 7'd1;
                wrap_q <= 1'b0;
              end
            end else if (ch == ChCr) begin
              col_q <= '0;
            end else if (ch == ChLf) begin
              col_q   <= '0;
              row_q   <= row_adv;
              wr_en_q <= 1'b1;
              waddr_q <= row_word(row_adv, 10'd0);
              wdata_q <= Blank;
              wstrb_q <= '1;
              cnt_q   <= 10'd1;
              state_q <= StClearRow;
            end else if ((ch == ChBs) && (col_q != 7'd0)) begin
              col_q   <= tgt_col;
              wrap_q  <= 1'b0;
              wr_en_q <= 1'b1;
              waddr_q <= char_addr;
              wdata_q <= char_data;
              wstrb_q <= char_strb;
              state_q <= StWrite;
            end else if (ch == ChFf) begin
              col_q   <= '0;
              row_q   <= '0;
              wr_en_q <= 1'b1;
              waddr_q <= '0;
              wdata_q <= Blank;
              wstrb_q <= '1;
              cnt_q   <= 10'd1;
              state_q <= StClearAll;
            end
          end
        end
        StWrite: begin
          // Row already advanced at accept time; start blanking the new row.
          if (wrap_q) begin
            wr_en_q <= 1'b1;
            waddr_q <= row_word(row_q, 10'd0);
            wdata_q <= Blank;
            wstrb_q <= '1;
            cnt_q   <= 10'd1;
            state_q <= StClearRow;
          end else begin
            state_q <= StIdle;
          end
        end
        StClearRow: begin
          if (cnt_q == RowWords) begin
            state_q <= StIdle;
          end else begin
            wr_en_q <= 1'b1;
            waddr_q <= row_word(row_q, cnt_q);
            wdata_q <= Blank;
            wstrb_q <= '1;
            cnt_q   <= cnt_q + 10'd1;
          end
        end
        StClearAll: begin
          // cnt_q is the next word to emit; after reset nothing has been emitted yet.
          if (cnt_q == AllWords) begin
            state_q <= StIdle;
          end else begin
            wr_en_q <= 1'b1;
            waddr_q <= BUF_ADDR_WIDTH'(cnt_q);
            wdata_q <= Blank;
            wstrb_q <= '1;
            cnt_q   <= cnt_q + 10'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.char_ready_o = (state_q == StIdle);
  assign bus_io.busy_o       = (state_q != StIdle);
  assign bus_io.buf_wr_en_o  = wr_en_q;
  assign bus_io.buf_waddr_o  = waddr_q;
  assign bus_io.buf_wdata_o  = wdata_q;
  assign bus_io.buf_wstrb_o  = wstrb_q;
  assign bus_io.cursor_col_o = col_q;
  assign bus_io.cursor_row_o = row_q;

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Directed bench for vga_text_ctrl: reset clear, printing, wrap, LF wrap, BS, CR, FF with reset abort.
module tb_vga_text_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_text_if bus ();

  vga_text_ctrl dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  logic [9:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];

  task automatic send_byte(input logic [7:0] c);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.char_ready_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.char_ready_o) begin
      checks++;
      errors++;
      $display("FAIL send_ready_timeout: char_ready_o=%0b required 1", bus.char_ready_o);
    end
    bus.char_valid_i = 1'b1;
    bus.char_data_i  = c;
    @(posedge clk);
    #1;
    bus.char_valid_i = 1'b0;
  endtask

  // Records every write until char_ready_o is seen; cycles counts sampled cycles.
  task automatic collect(input int bound, output int cycles);
    bit done;
    done = 1'b0;
    cycles = 0;
    wa_q.delete();
    wd_q.delete();
    ws_q.delete();
    while (!done && cycles < bound) begin
      @(negedge clk);
      cycles++;
      if (bus.buf_wr_en_o) begin
        wa_q.push_back(bus.buf_waddr_o);
        wd_q.push_back(bus.buf_wdata_o);
        ws_q.push_back(bus.buf_wstrb_o);
      end
      if (bus.char_ready_o) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL collect_timeout: no ready within %0d cycles, required ready", bound);
    end
  endtask

  task automatic test_reset;
    int cyc, bad;
    rst = 1'b1;
    bus.char_valid_i = 1'b0;
    bus.char_data_i  = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.char_ready_o !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %0b required 0", bus.char_ready_o);
    end
    checks++;
    if (bus.busy_o !== 1'b1) begin
      errors++; $display("FAIL reset_busy: got %0b required 1", bus.busy_o);
    end
    checks++;
    if ({bus.buf_wr_en_o, bus.buf_waddr_o, bus.buf_wdata_o, bus.buf_wstrb_o} !== 47'd0) begin
      errors++;
      $display("FAIL reset_buf: en=%0b addr=%0d data=%h strb=%h required all 0",
               bus.buf_wr_en_o, bus.buf_waddr_o, bus.buf_wdata_o, bus.buf_wstrb_o);
    end
    checks++;
    if ({bus.cursor_row_o, bus.cursor_col_o} !== 12'd0) begin
      errors++; $display("FAIL reset_cursor: got (%0d,%0d) required (0,0)",
                         bus.cursor_row_o, bus.cursor_col_o);
    end
    rst = 1'b0;
    collect(2000, cyc);
    checks++;
    if (wa_q.size() != 600) begin
      errors++; $display("FAIL reset_clear_count: got %0d required 600", wa_q.size());
    end
    bad = 0;
    foreach (wa_q[i])
      if (wa_q[i] !== 10'(i) || wd_q[i] !== 32'h20202020 || ws_q[i] !== 4'hF) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL reset_clear_words: %0d bad words, required 0", bad);
    end
    checks++;
    if (cyc != 601) begin
      errors++; $display("FAIL reset_clear_cycles: ready after %0d cycles, required 601", cyc);
    end
    checks++;
    if ({bus.cursor_row_o, bus.cursor_col_o} !== 12'd0) begin
      errors++; $display("FAIL reset_clear_cursor: got (%0d,%0d) required (0,0)",
                         bus.cursor_row_o, bus.cursor_col_o);
    end
  endtask

  task automatic test_print_ab;
    int cyc;
    logic [9:0] a0;
    logic [31:0] d0;
    logic [3:0] s0;
    send_byte(8'h41);
    collect(20, cyc);
    a0 = (wa_q.size() > 0) ? wa_q[0] : 10'h3FF;
    d0 = (wd_q.size() > 0) ? wd_q[0] : 32'hFFFFFFFF;
    s0 = (ws_q.size() > 0) ? ws_q[0] : 4'hF;
    checks++;
    if (wa_q.size() != 1 || a0 !== 10'd0 || s0 !== 4'b0001 || d0 !== 32'h41414141) begin
      errors++; $display("FAIL print_A: n=%0d addr=%0d strb=%b data=%h required 1/0/0001/41414141",
                         wa_q.size(), a0, s0, d0);
    end
    checks++;
    if (cyc != 2) begin
      errors++; $display("FAIL print_A_latency: ready after %0d cycles, required 2", cyc);
    end
    send_byte(8'h42);
    collect(20, cyc);
    a0 = (wa_q.size() > 0) ? wa_q[0] : 10'h3FF;
    d0 = (wd_q.size() > 0) ? wd_q[0] : 32'hFFFFFFFF;
    s0 = (ws_q.size() > 0) ? ws_q[0] : 4'hF;
    checks++;
    if (wa_q.size() != 1 || a0 !== 10'd0 || s0 !== 4'b0010 || d0 !== 32'h42424242) begin
      errors++; $display("FAIL print_B: n=%0d addr=%0d strb=%b data=%h required 1/0/0010/42424242",
                         wa_q.size(), a0, s0, d0);
    end
    checks++;
    if (bus.cursor_col_o !== 7'd2 || bus.cursor_row_o !== 5'd0) begin
      errors++; $display("FAIL print_cursor: got (%0d,%0d) required (0,2)",
                         bus.cursor_row_o, bus.cursor_col_o);
    end
  endtask

  task automatic test_cr_ignored;
    int cyc;
    send_byte(8'h0D);
    collect(20, cyc);
    checks++;
    if (wa_q.size() != 0 || cyc != 1 || bus.cursor_col_o !== 7'd0) begin
      errors++; $display("FAIL cr: writes=%0d cycles=%0d col=%0d required 0/1/0",
                         wa_q.size(), cyc, bus.cursor_col_o);
    end
    send_byte(8'h01);
    collect(20, cyc);
    checks++;
    if (wa_q.size() != 0 || cyc != 1 || {bus.cursor_row_o, bus.cursor_col_o} !== 12'd0) begin
      errors++; $display("FAIL ignored_01: writes=%0d cycles=%0d required 0/1", wa_q.size(), cyc);
    end
    send_byte(8'h7F);
    collect(20, cyc);
    checks++;
    if (wa_q.size() != 0 || cyc != 1) begin
      errors++; $display("FAIL ignored_7f: writes=%0d cycles=%0d required 0/1", wa_q.size(), cyc);
    end
  endtask

  task automatic test_backspace;
    int cyc;
    logic [9:0] a0;
    logic [31:0] d0;
    logic [3:0] s0;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h61 + 8'(i));
      collect(20, cyc);
    end
    checks++;
    if (bus.cursor_col_o !== 7'd3) begin
      errors++; $display("FAIL bs_setup_col: got %0d required 3", bus.cursor_col_o);
    end
    send_byte(8'h08);
    collect(20, cyc);
    a0 = (wa_q.size() > 0) ? wa_q[0] : 10'h3FF;
    d0 = (wd_q.size() > 0) ? wd_q[0] : 32'hFFFFFFFF;
    s0 = (ws_q.size() > 0) ? ws_q[0] : 4'hF;
    checks++;
    if (wa_q.size() != 1 || a0 !== 10'd0 || s0 !== 4'b0100 || d0 !== 32'h20202020) begin
      errors++; $display("FAIL bs_write: n=%0d addr=%0d strb=%b data=%h required 1/0/0100/20202020",
                         wa_q.size(), a0, s0, d0);
    end
    checks++;
    if (bus.cursor_col_o !== 7'd2) begin
      errors++; $display("FAIL bs_col: got %0d required 2", bus.cursor_col_o);
    end
    send_byte(8'h0D);
    collect(20, cyc);
    send_byte(8'h08);
    collect(20, cyc);
    checks++;
    if (wa_q.size() != 0 || cyc != 1 || bus.cursor_col_o !== 7'd0) begin
      errors++; $display("FAIL bs_col0: writes=%0d cycles=%0d col=%0d required 0/1/0",
                         wa_q.size(), cyc, bus.cursor_col_o);
    end
  endtask

  task automatic test_wrap;
    int cyc, bad;
    send_byte(8'h0A);
    collect(100, cyc);
    bad = 0;
    foreach (wa_q[i]) if (wa_q[i] !== 10'(20 + i) || ws_q[i] !== 4'hF) bad++;
    checks++;
    if (wa_q.size() != 20 || bad != 0 || cyc != 21) begin
      errors++; $display("FAIL lf_clear: n=%0d bad=%0d cycles=%0d required 20/0/21",
                         wa_q.size(), bad, cyc);
    end
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h0A);
      collect(100, cyc);
    end
    for (int i = 0; i < 79; i++) begin
      send_byte(8'h78);
      collect(100, cyc);
    end
    checks++;
    if (bus.cursor_row_o !== 5'd5 || bus.cursor_col_o !== 7'd79) begin
      errors++; $display("FAIL wrap_setup: got (%0d,%0d) required (5,79)",
                         bus.cursor_row_o, bus.cursor_col_o);
    end
    send_byte(8'h5A);
    collect(100, cyc);
    checks++;
    if (wa_q.size() != 21) begin
      errors++; $display("FAIL wrap_count: got %0d writes required 21", wa_q.size());
    end else begin
      checks++;
      if (wa_q[0] !== 10'd119 || ws_q[0] !== 4'b1000 || wd_q[0] !== 32'h5A5A5A5A) begin
        errors++; $display("FAIL wrap_char: addr=%0d strb=%b data=%h required 119/1000/5a5a5a5a",
                           wa_q[0], ws_q[0], wd_q[0]);
      end
      bad = 0;
      for (int i = 1; i < 21; i++)
        if (wa_q[i] !== 10'(119 + i) || ws_q[i] !== 4'hF || wd_q[i] !== 32'h20202020) bad++;
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL wrap_clear: %0d bad words, required 0", bad);
      end
    end
    checks++;
    if (cyc != 22 || bus.cursor_row_o !== 5'd6 || bus.cursor_col_o !== 7'd0) begin
      errors++; $display("FAIL wrap_end: cycles=%0d cursor=(%0d,%0d) required 22 (6,0)",
                         cyc, bus.cursor_row_o, bus.cursor_col_o);
    end
  endtask

  task automatic test_lf_wrap;
    int cyc, bad;
    for (int i = 0; i < 23; i++) begin
      send_byte(8'h0A);
      collect(100, cyc);
    end
    checks++;
    if (bus.cursor_row_o !== 5'd29) begin
      errors++; $display("FAIL lf_wrap_setup: row=%0d required 29", bus.cursor_row_o);
    end
    send_byte(8'h0A);
    collect(100, cyc);
    bad = 0;
    foreach (wa_q[i]) if (wa_q[i] !== 10'(i) || wd_q[i] !== 32'h20202020) bad++;
    checks++;
    if (wa_q.size() != 20 || bad != 0) begin
      errors++; $display("FAIL lf_wrap_clear: n=%0d bad=%0d required 20/0", wa_q.size(), bad);
    end
    checks++;
    if ({bus.cursor_row_o, bus.cursor_col_o} !== 12'd0) begin
      errors++; $display("FAIL lf_wrap_cursor: got (%0d,%0d) required (0,0)",
                         bus.cursor_row_o, bus.cursor_col_o);
    end
  endtask

  task automatic test_ff_reset;
    int cyc, bad, nw, guard;
    send_byte(8'h0A);
    collect(100, cyc);
    send_byte(8'h51);
    collect(100, cyc);
    send_byte(8'h0C);
    checks++;
    if ({bus.cursor_row_o, bus.cursor_col_o} !== 12'd0 || bus.busy_o !== 1'b1) begin
      errors++; $display("FAIL ff_cursor: got (%0d,%0d) busy=%0b required (0,0) busy=1",
                         bus.cursor_row_o, bus.cursor_col_o, bus.busy_o);
    end
    nw = 0;
    bad = 0;
    guard = 0;
    while (nw < 100 && guard < 300) begin
      @(negedge clk);
      guard++;
      if (bus.buf_wr_en_o) begin
        if (bus.buf_waddr_o !== 10'(nw)) bad++;
        nw++;
      end
    end
    checks++;
    if (nw != 100 || bad != 0 || guard != 100) begin
      errors++; $display("FAIL ff_first100: writes=%0d bad=%0d cycles=%0d required 100/0/100",
                         nw, bad, guard);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.buf_wr_en_o !== 1'b0 || bus.buf_waddr_o !== 10'd0 || bus.busy_o !== 1'b1 ||
        bus.char_ready_o !== 1'b0) begin
      errors++; $display("FAIL ff_abort: en=%0b addr=%0d busy=%0b ready=%0b required 0/0/1/0",
                         bus.buf_wr_en_o, bus.buf_waddr_o, bus.busy_o, bus.char_ready_o);
    end
    @(negedge clk);
    checks++;
    if (bus.buf_wr_en_o !== 1'b0) begin
      errors++; $display("FAIL ff_abort_hold: en=%0b required 0", bus.buf_wr_en_o);
    end
    rst = 1'b0;
    collect(2000, cyc);
    bad = 0;
    foreach (wa_q[i]) if (wa_q[i] !== 10'(i) || ws_q[i] !== 4'hF) bad++;
    checks++;
    if (wa_q.size() != 600 || bad != 0) begin
      errors++; $display("FAIL ff_restart: n=%0d bad=%0d required 600/0", wa_q.size(), bad);
    end
  endtask

  initial begin
    test_reset();
    test_print_ab();
    test_cr_ignored();
    test_backspace();
    test_wrap();
    test_lf_wrap();
    test_ff_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
